mux_arbiter4: RTL
=================

// Module: mux_arbiter4
// PURPOSE
//  - Round-robin arbiter and sequencer for a shared 4:1 mux path (mux41 instance).
//  - Four requesters share one resource. The block grants it to one at a time,
//    drives the 2-bit mux select, holds the grant for the transaction and releases it.
//  - Sits between requesting units (regfile ports, ALU operand sources) and the select input of mux41.
// PARAMETERS
//  MAX_HOLD  16  maximum cycles one owner may hold a grant before forced release (>=2)
//  HOLD_W    4   width of hold counter; must satisfy 2**HOLD_W >= MAX_HOLD
// PORTS
//  clk      in   1  single clock, all state updates on rising edge
//  rst_n    in   1  synchronous active-low reset, sampled on rising clk
//  req      in   4  request per requester, level; bit i = requester i
//  done     in   1  current owner ends transaction (single-cycle pulse)
//  gnt      out  4  one-hot grant, registered; all-zero when no owner
//  sel      out  2  mux select = encoded owner index; feeds mux41 s[1:0]
//  busy     out  1  high while a grant is active (gnt != 0)
//  timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge):
//    - state=IDLE; gnt=0, sel=0, busy=0, timeout=0, hold counter=0.
//    - last_owner=3, so requester 0 has top priority first.
//  - States (2-bit encoding): IDLE=2'b00, BUSY=2'b01.
//  - IDLE:
//    - If req!=0 at an edge, pick the first set bit scanning last_owner+1, +2, +3, +4 (mod 4).
//    - At that same edge: gnt=onehot(pick), sel=pick, busy=1, counter=0, state->BUSY.
//    - Latency: request visible at edge N gives grant after edge N (one cycle).
//    - If req==0: stay IDLE. sel holds its previous value so the mux output stays stable.
//  - BUSY: counter increments by 1 each cycle. Release at the edge where any of these holds:
//    (a) done=1,
//    (b) req[owner]=0,
//    (c) counter==MAX_HOLD-1.
//  - On release:
//    - gnt=0, busy=0, last_owner=owner, state->IDLE; sel keeps the owner value.
//    - timeout=1 for exactly one cycle, only when (c) caused release and (a) and (b) did not.
//  - One dead cycle (gnt=0) follows every release. Re-arbitration happens in IDLE at the following edge.
//  - Simultaneous events:
//    - done together with the owner's req still high: release anyway. The owner becomes lowest priority.
//    - done and (c) in the same cycle: timeout stays 0.
//    - done while IDLE: ignored.
//    - req bits of non-owners changing during BUSY: ignored until the next IDLE.
//  - Reset mid-BUSY: everything clears at that edge and priority restarts at requester 0.
//  - Invariants:
//    - gnt is always zero or one-hot.
//    - sel==index(gnt) whenever busy=1.
//    - Counter never exceeds MAX_HOLD-1.
// STRUCTURE
//  - Shared include arb_defs.vh holds:
//    - state encodings ST_IDLE and ST_BUSY;
//    - NREQ=4 and SEL_W=2;
//    - default MAX_HOLD.
//  - Sub-module rr_pick4 (combinational):
//    - inputs req[3:0] and last[1:0];
//    - outputs pick[1:0] and any.
//    - Rotating priority encoder, instantiated once.
//  - Top level: FSM register, hold counter, last_owner register, gnt/sel/busy/timeout output registers.
// TESTING
//  1. rst_n=0 for 2 cycles with req=4'b1111, then release
//     -> first edge after release: gnt=0001, sel=0, busy=1.
//  2. req=1111 held, done pulsed 2 cycles after each grant
//     -> grant order 0,1,2,3,0 with one gnt=0 cycle between grants.
//  3. MAX_HOLD=16, req=0001 held, no done
//     -> gnt=0001 for exactly 16 cycles, timeout=1 for one cycle, then gnt=0001 again after the dead cycle.
//  4. Owner 2 granted, then req[2] dropped while req=1011
//     -> gnt=0 at the next edge, then gnt=1000 (3 follows 2), sel=3.
//  5. rst_n=0 for one edge while gnt=0100 with counter=7
//     -> gnt=0, sel=0, busy=0 after that edge; with req=1111, next grant goes to 0.
//  6. done pulsed while IDLE and req=0 -> no state change, gnt=0, sel unchanged, timeout=0.

Source files
------------

// File: rtl/mux_arbiter4_pkg.sv
// mux_arbiter4_pkg: shared definitions for the 4-way round-robin mux arbiter.
//   NREQ / SEL_W   : requester count and encoded select width
//   MAX_HOLD_DEF   : default forced-release hold limit in cycles
//   arb_state_e    : FSM state encoding (IDLE=00, BUSY=01)
//   onehot()       : encoded index -> one-hot grant vector
package mux_arbiter4_pkg;

  localparam int NREQ         = 4;
  localparam int SEL_W        = 2;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01
  } arb_state_e;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_arbiter4_rr_pick4.sv
// rr_pick4: combinational rotating-priority encoder.
//   req  [NREQ-1:0]  : request vector, bit i = requester i
//   last [SEL_W-1:0] : previous owner; it gets the lowest priority
//   pick [SEL_W-1:0] : first requester set scanning last+1 .. last+NREQ (mod NREQ)
//   any              : at least one request present (pick is 0 otherwise)
module rr_pick4
  import mux_arbiter4_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  // Scan from the farthest candidate toward the nearest; the last hit
  // written is the nearest one after 'last', which is the winner.
  // Offset NREQ wraps to 'last' itself, so the previous owner still wins
  // when it is the only requester.
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx  = '0;
    pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) pick = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_arbiter4.sv
// mux_arbiter4: round-robin arbiter / sequencer driving the select of a
// shared 4:1 mux. One owner at a time; the grant is held until the owner
// signals done, drops its request, or hits the MAX_HOLD limit. Every release
// is followed by one dead cycle before re-arbitration.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   req[3:0] : level requests
//   done     : owner ends its transaction (pulse)
//   gnt[3:0] : registered one-hot grant, zero when idle
//   sel[1:0] : encoded owner index to the mux; held through idle cycles
//   busy     : grant active
//   timeout  : one-cycle pulse on a hold-limit forced release
module mux_arbiter4
  import mux_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  arb_state_e       state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SEL_W-1:0]  last_owner;

  logic [SEL_W-1:0]  pick;
  logic              any;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_owner),
    .pick (pick),
    .any  (any)
  );

  // sel is the owner register while BUSY; release causes are all taken
  // from the current registered state so they line up with the edge.
  logic rel_done, rel_drop, rel_hold, release_now;

  always_comb begin
    rel_done    = done;
    rel_drop    = ~req[sel];
    rel_hold    = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    release_now = rel_done | rel_drop | rel_hold;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      sel        <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= SEL_W'(NREQ - 1);   // requester 0 first after reset
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          // done is ignored here; sel keeps its value so the mux is stable
          if (any) begin
            gnt      <= onehot(pick);
            sel      <= pick;
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (release_now) begin
            gnt        <= '0;
            busy       <= 1'b0;
            last_owner <= sel;
            hold_cnt   <= '0;
            state      <= ST_IDLE;
            // flag only a pure hold-limit release
            timeout    <= rel_hold & ~rel_done & ~rel_drop;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
